// File: rtl/alu_exec_unit.sv
// Sequential execution unit: single-cycle logic/add/sub/pass-B and an iterative shift-add multiply.
// Optional: define ALU_MUL_EARLY_EXIT_EN to end the multiply once the remaining multiplier is zero.
module alu_exec_unit #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       operation,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             negative,
   output logic             carry,
   output logic             overflow,
   output logic             illegal,
   output logic             busy
);
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [3:0] OP_AND = 4'b0000, OP_ORR = 4'b0001, OP_ADD = 4'b0010,
                          OP_SUB = 4'b0110, OP_PSB = 4'b0111, OP_MUL = 4'b0101;

   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
   state_t state_q, state_d;

   logic [WIDTH-1:0] acc_q, mcand_q, mplier_q;
   logic [CW-1:0]    cnt_q;

   logic [WIDTH:0]   sum, diff;
   logic [WIDTH-1:0] alu_res, acc_nxt, mplier_nxt;
   logic             alu_c, alu_v, alu_ill, mul_last;

   always_comb begin
      sum     = {1'b0, a} + {1'b0, b};
      diff    = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      alu_ill = 1'b0;
      case (operation)
         OP_AND: alu_res = a & b;
         OP_ORR: alu_res = a | b;
         OP_PSB: alu_res = b;
         OP_MUL: alu_res = '0;
         OP_ADD: begin
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            // carry out of a + ~b + 1 is the not-borrow flag
            alu_res = diff[WIDTH-1:0];
            alu_c   = diff[WIDTH];
            alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         default: alu_ill = 1'b1;
      endcase
   end

   always_comb begin
      acc_nxt    = mplier_q[0] ? acc_q + mcand_q : acc_q;
      mplier_nxt = mplier_q >> 1;
`ifdef ALU_MUL_EARLY_EXIT_EN
      mul_last   = (mplier_nxt == '0) || (cnt_q == CW'(WIDTH - 1));
`else
      mul_last   = (cnt_q == CW'(WIDTH - 1));
`endif
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid) state_d = (operation == OP_MUL) ? MUL : DONE;
         MUL:     if (mul_last) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result   <= '0;
         zero     <= 1'b0;
         negative <= 1'b0;
         carry    <= 1'b0;
         overflow <= 1'b0;
         illegal  <= 1'b0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else begin
         case (state_q)
            IDLE: if (in_valid) begin
               illegal <= alu_ill;
               if (operation == OP_MUL) begin
                  acc_q    <= '0;
                  mcand_q  <= a;
                  mplier_q <= b;
                  cnt_q    <= '0;
               end else begin
                  // illegal codes fall out as result 0, Z=1, C=V=0
                  result   <= alu_res;
                  zero     <= (alu_res == '0);
                  negative <= alu_res[WIDTH-1];
                  carry    <= alu_c;
                  overflow <= alu_v;
               end
            end
            MUL: begin
               acc_q    <= acc_nxt;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_nxt;
               cnt_q    <= cnt_q + CW'(1);
               if (mul_last) begin
                  result   <= acc_nxt;
                  zero     <= (acc_nxt == '0);
                  negative <= acc_nxt[WIDTH-1];
                  carry    <= 1'b0;
                  overflow <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed + randomized bench for alu_exec_unit against an arithmetic reference model.
module tb_alu_exec_unit;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        in_valid = 1'b0, out_ready = 1'b0;
   logic [3:0]  op_s = '0;
   logic [63:0] a_s = '0, b_s = '0;
   logic        in_ready, out_valid, zero, negative, carry, overflow, illegal, busy;
   logic [63:0] result;
   int          checks = 0, errors = 0;

   alu_exec_unit #(.WIDTH(64)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .operation(op_s), .a(a_s), .b(b_s), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .negative(negative), .carry(carry),
      .overflow(overflow), .illegal(illegal), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: plain wide arithmetic from the operation definitions
   function automatic void model(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y,
                                 output logic [63:0] r, output logic z, output logic n,
                                 output logic c, output logic v, output logic ill);
      logic [127:0]        p;
      logic signed [127:0] s, rs;
      r = '0; c = 1'b0; v = 1'b0; ill = 1'b0;
      case (op)
         4'b0000: r = x & y;
         4'b0001: r = x | y;
         4'b0111: r = y;
         4'b0101: begin p = {64'd0, x} * {64'd0, y}; r = p[63:0]; end
         4'b0010: begin
            p = {64'd0, x} + {64'd0, y}; r = p[63:0]; c = (p > 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF);
            s = $signed({{64{x[63]}}, x}) + $signed({{64{y[63]}}, y});
            rs = $signed({{64{r[63]}}, r}); v = (s != rs);
         end
         4'b0110: begin
            r = x - y; c = (x >= y);
            s = $signed({{64{x[63]}}, x}) - $signed({{64{y[63]}}, y});
            rs = $signed({{64{r[63]}}, r}); v = (s != rs);
         end
         default: ill = 1'b1;
      endcase
      z = (r == '0); n = r[63];
   endfunction

   function automatic int exp_latency(input logic [3:0] op, input logic [63:0] y);
      int hb;
      if (op != 4'b0101) return 1;
`ifdef ALU_MUL_EARLY_EXIT_EN
      if (y == '0) return 2;
      hb = 0;
      for (int i = 0; i < 64; i++) if (y[i]) hb = i;
      return hb + 2;
`else
      hb = 0;
      return 65 + hb;
`endif
   endfunction

   task automatic run_op(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y,
                         input int hold, input string tag);
      logic [63:0] er;
      logic        ez, en, ec, ev, ei;
      int          cyc;
      model(op, x, y, er, ez, en, ec, ev, ei);
      @(negedge clk);
      in_valid = 1'b1; op_s = op; a_s = x; b_s = y;
      @(posedge clk); #1;
      in_valid = 1'b0; cyc = 1;
      while (!out_valid && cyc < 200) begin @(posedge clk); #1; cyc++; end
      check({tag, "_lat"}, 64'(cyc), 64'(exp_latency(op, y)));
      check({tag, "_res"}, result, er);
      check({tag, "_flags"}, {59'd0, zero, negative, carry, overflow, illegal},
            {59'd0, ez, en, ec, ev, ei});
      check({tag, "_busy"}, {62'd0, in_ready, busy}, {62'd0, 1'b0, 1'b1});
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         in_valid = 1'b1; op_s = 4'b0010; a_s = $urandom; b_s = $urandom;
         @(posedge clk); #1;
         in_valid = 1'b0;
         check({tag, "_hold"}, {result, 1'b0}, {er, 1'b0});
         check({tag, "_holdctl"}, {59'd0, out_valid, in_ready, zero, negative, carry},
               {59'd0, 1'b1, 1'b0, ez, en, ec});
      end
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
      check({tag, "_rel"}, {62'd0, out_valid, in_ready}, {62'd0, 1'b0, 1'b1});
      check({tag, "_idle_res"}, result, er);
   endtask

   initial begin
      logic [3:0] ops [7];
      logic [3:0] rop;
      logic [63:0] ra, rb;
      ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b1111};
      #2;
      check("rst_ctl", {59'd0, in_ready, out_valid, busy, illegal, zero}, {59'd0, 5'b10000});
      check("rst_res", result, 64'd0);
      @(negedge clk); rst_n = 1'b1;

      run_op(4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, "add_ovf");
      run_op(4'b0110, 64'd5, 64'd5, 0, "sub_eq");
      run_op(4'b0110, 64'd3, 64'd5, 0, "sub_neg");
      run_op(4'b0000, 64'hF0F0, 64'hFF00, 0, "and");
      run_op(4'b0001, 64'hF0F0, 64'hFF00, 0, "orr");
      run_op(4'b0111, 64'h1234, 64'd0, 0, "passb0");
      run_op(4'b1111, 64'h55, 64'h66, 0, "illegal");
      run_op(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, "add_carry");
      run_op(4'b0101, 64'h1_0000_0003, 64'd7, 0, "mul7");
      run_op(4'b0101, 64'hDEAD, 64'd0, 0, "mul_b0");
      run_op(4'b0101, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0003, 0, "mul_top");
      run_op(4'b0010, 64'd10, 64'd20, 10, "backpressure");

      // asynchronous reset in the middle of a multiply
      @(negedge clk);
      in_valid = 1'b1; op_s = 4'b0101; a_s = 64'd9; b_s = 64'hFFFF;
      @(posedge clk); #1; in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_mul", {60'd0, out_valid, in_ready, busy, illegal}, {60'd0, 4'b0100});
      check("rst_mid_res", result, 64'd0);
      @(negedge clk); rst_n = 1'b1;

      for (int t = 0; t < 40; t++) begin
         rop = ops[$urandom_range(0, 6)];
         ra  = {$urandom, $urandom};
         rb  = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 255)) : {$urandom, $urandom};
         if ($urandom_range(0, 4) == 0) rb = ra;
         run_op(rop, ra, rb, $urandom_range(0, 2), "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Sequential 64-bit execution unit that consumes the 4-bit Operation code produced by the team's ALU control decoder, plus two operands, and returns a result with NZCV flags.
- Single-cycle ops (AND, ORR, ADD, SUB, PASS-B) complete in one cycle. The multiply op runs as an iterative shift-add.
- Sits between the register-read stage and writeback. Valid/ready handshakes on both sides.

Parameters:
- WIDTH, 64, operand/result width in bits; multiply iteration count equals WIDTH.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  unit can accept a request
- operation  input  4  op code: 0000 AND, 0001 ORR, 0010 ADD, 0110 SUB, 0111 PASS-B, 0101 MUL
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- result  output  WIDTH  result
- zero  output  1  result == 0
- negative  output  1  result[WIDTH-1]
- carry  output  1  carry out / not-borrow
- overflow  output  1  signed overflow
- illegal  output  1  operation code not in the list above
- busy  output  1  state != IDLE

Behaviour:
- Clock and reset: one clock domain, clk. Reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, all flags=0, illegal=0, busy=0.
- States: IDLE, MUL, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, latch a, b and operation.
  - Non-MUL op: compute and register result/flags, then go to DONE.
  - MUL op: clear accumulator, set multiplicand=a, multiplier=b, count=0, then go to MUL.
- MUL: each cycle,
  - if multiplier[0]=1, then accumulator += multiplicand (mod 2^WIDTH);
  - multiplicand <<= 1; multiplier >>= 1; count++;
  - after WIDTH iterations, go to DONE.
  - Result is the low WIDTH bits of the unsigned product.
- DONE:
  - out_valid=1. result and flags are held stable until out_ready=1.
  - On out_ready, go to IDLE; out_valid drops next cycle.
  - A new request cannot be accepted in the same cycle.
- in_ready=1 only in IDLE. in_valid is ignored elsewhere.
- Latency (request accepted at edge k):
  - single-cycle ops: out_valid=1 after edge k+1;
  - MUL: out_valid=1 after edge k+WIDTH+1.
- Throughput: at most one op per 2 cycles (single-cycle ops).
- Arithmetic: computed at WIDTH+1 bits, result truncated to WIDTH.
- ADD flags:
  - C = carry out of bit WIDTH-1;
  - V = (a[msb]==b[msb]) && (r[msb]!=a[msb]).
- SUB:
  - result = a + ~b + 1;
  - C = 1 when there is no borrow (a >= b unsigned);
  - V = (a[msb]!=b[msb]) && (r[msb]!=a[msb]).
- AND, ORR, PASS-B, MUL: C=0, V=0. Z and N are always derived from result.
- Illegal code: result=0, Z=1, other flags 0, illegal=1, completes as a single-cycle op. illegal is cleared on the next accepted request.
- Outputs keep their last values while in IDLE; out_valid is the only qualifier.
- Reset mid-MUL or mid-DONE aborts immediately to reset values. No partial result is delivered.

Optional Feature:
- Macro: ALU_MUL_EARLY_EXIT_EN.
- Defined: in MUL, if the remaining multiplier (after the current shift) is 0, go to DONE at the end of that cycle. Latency becomes (index of highest set bit of b)+2 cycles, or 1 MUL cycle when b=0. Result is identical.
- Undefined: MUL always takes exactly WIDTH iterations.

Test Plan:
- Reset: rst_n=0 asynchronously mid-MUL -> out_valid=0, result=0, in_ready=1 with no clock edge needed.
- ADD: a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> result=0x8000_0000_0000_0000, N=1, V=1, C=0, Z=0, out_valid one cycle after accept.
- SUB: a=5, b=5 -> result 0, Z=1, C=1. Then a=3, b=5 -> result=0xFFFF_FFFF_FFFF_FFFE, N=1, C=0.
- Logical/pass: AND a=0xF0F0, b=0xFF00 -> 0xF000. ORR -> 0xFFF0. PASS-B (0111) b=0 -> Z=1. Illegal 1111 -> illegal=1, result=0.
- MUL: a=0x1_0000_0003, b=7 -> result 0x7_0000_0015.
  - Without macro: out_valid exactly 65 cycles after accept.
  - With ALU_MUL_EARLY_EXIT_EN: out_valid after 4 cycles.
- Backpressure: out_ready=0 for 10 cycles after completion -> result and flags stable, in_ready=0, in_valid pulses ignored. Release -> in_ready=1 the following cycle.
